// File: rtl/fft_sample_loader_if.sv
// Bus between the sample loader and its neighbours: sample capture
// strobe, abort, and the valid/ready stream toward the FFT core.
interface fft_sample_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              clear;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_last;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              dropped;

  // Producer/consumer side that drives samples and accepts the stream
  modport master (
    output in_data, in_valid, clear, out_ready,
    input  out_data, out_index, out_valid, out_last, count, full, dropped
  );

  // The loader itself
  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output out_data, out_index, out_valid, out_last, count, full, dropped
  );
endinterface

// File: rtl/fft_sample_loader.sv
// Sample loader in front of the FFT core. Fills a frame buffer one sample
// per strobe, then streams the whole frame out over valid/ready, optionally
// in bit-reversed index order so a radix-2 DIT core can take it directly.
module fft_sample_loader #(
  parameter int N_SAMPLES   = 16,
  parameter int ADDR_W      = $clog2(N_SAMPLES),
  parameter int DATA_W      = 8,
  parameter bit BIT_REVERSE = 1'b1
) (
  input logic clk,
  input logic rst,
  fft_sample_loader_if.slave bus
);

  typedef enum logic {FILL, STREAM} state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(N_SAMPLES);
  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(N_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(N_SAMPLES - 1);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] mem [N_SAMPLES];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_index;
  logic [ADDR_W:0]   count;
  logic              dropped_q;
  logic              capture;
  logic              transfer;
  logic              last_transfer;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = v[ADDR_W-1-i];
    end
    return r;
  endfunction

  // Qualified events; clear overrides both capture and transfer
  always_comb begin
    capture       = (state == FILL) && bus.in_valid && !bus.clear;
    transfer      = (state == STREAM) && bus.out_ready && !bus.clear;
    last_transfer = transfer && (rd_ptr == LAST_PTR);
    rd_index      = BIT_REVERSE ? bitrev(rd_ptr) : rd_ptr;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next state: frame completes on the last capture, drains on the last transfer
  always_comb begin
    next_state = state;
    if (bus.clear) begin
      next_state = FILL;
    end else begin
      case (state)
        FILL:    if (capture && (count == LAST_COUNT)) next_state = STREAM;
        STREAM:  if (last_transfer) next_state = FILL;
        default: next_state = FILL;
      endcase
    end
  end

  // Pointers, sample count and the dropped-strobe pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= (state == STREAM) && bus.in_valid;
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL_COUNT) count <= count + 1'b1;
      end
      if (transfer) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (last_transfer) count <= '0;
      end
    end
  end

  // Frame buffer; contents survive reset and are only meaningful once full
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= bus.in_data;
  end

  // Stream outputs: combinational read at the (possibly bit-reversed) index
  always_comb begin
    bus.out_valid = (state == STREAM);
    bus.full      = (state == STREAM);
    bus.out_last  = (state == STREAM) && (rd_ptr == LAST_PTR);
    bus.out_index = rd_index;
    bus.out_data  = mem[rd_index];
    bus.count     = count;
    bus.dropped   = dropped_q;
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: a bit-reversed and a natural-order instance
// share the same stimulus and are both compared, every cycle, against a
// frame-level model (queue of captured samples plus a transfer count).
module tb_fft_sample_loader;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fft_sample_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rev ();
  fft_sample_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nat ();

  fft_sample_loader #(.N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1'b1))
    dut_rev (.clk(clk), .rst(rst), .bus(bus_rev.slave));
  fft_sample_loader #(.N_SAMPLES(N), .ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1'b0))
    dut_nat (.clk(clk), .rst(rst), .bus(bus_nat.slave));

  always #5 clk = ~clk;

  logic [DW-1:0] m_frame[$];
  bit            m_stream;
  int            m_sent;
  bit            m_drop;

  function automatic int rev_index(int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  task automatic modelReset();
    m_frame.delete();
    m_stream = 1'b0;
    m_sent   = 0;
    m_drop   = 1'b0;
  endtask

  task automatic modelUpdate(bit v, logic [DW-1:0] d, bit c, bit r);
    if (c) begin
      modelReset();
    end else if (!m_stream) begin
      m_drop = 1'b0;
      if (v) begin
        m_frame.push_back(d);
        if (m_frame.size() == N) begin
          m_stream = 1'b1;
          m_sent   = 0;
        end
      end
    end else begin
      m_drop = v;
      if (r) begin
        m_sent++;
        if (m_sent == N) begin
          m_stream = 1'b0;
          m_sent   = 0;
          m_frame.delete();
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOne(string name, bit is_rev, logic ov, logic fl, logic last,
                          logic [AW:0] cnt, logic drop, logic [AW-1:0] idx,
                          logic [DW-1:0] data);
    int e_idx;
    int e_cnt;
    e_idx = m_stream ? (is_rev ? rev_index(m_sent) : m_sent) : 0;
    e_cnt = m_stream ? N : m_frame.size();
    chk({name, ".out_valid"}, 32'(ov), 32'(m_stream));
    chk({name, ".full"}, 32'(fl), 32'(m_stream));
    chk({name, ".out_last"}, 32'(last), 32'(m_stream && (m_sent == N - 1)));
    chk({name, ".count"}, 32'(cnt), 32'(e_cnt));
    chk({name, ".dropped"}, 32'(drop), 32'(m_drop));
    chk({name, ".out_index"}, 32'(idx), 32'(e_idx));
    if (m_stream) chk({name, ".out_data"}, 32'(data), 32'(m_frame[e_idx]));
  endtask

  task automatic checkOutput();
    checkOne("rev", 1'b1, bus_rev.out_valid, bus_rev.full, bus_rev.out_last,
             bus_rev.count, bus_rev.dropped, bus_rev.out_index, bus_rev.out_data);
    checkOne("nat", 1'b0, bus_nat.out_valid, bus_nat.full, bus_nat.out_last,
             bus_nat.count, bus_nat.dropped, bus_nat.out_index, bus_nat.out_data);
  endtask

  task automatic drive(bit v, logic [DW-1:0] d, bit c, bit r);
    bus_rev.in_valid = v;  bus_nat.in_valid = v;
    bus_rev.in_data = d;   bus_nat.in_data = d;
    bus_rev.clear = c;     bus_nat.clear = c;
    bus_rev.out_ready = r; bus_nat.out_ready = r;
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at negedge
  task automatic applyStimulus(bit v, logic [DW-1:0] d, bit c, bit r);
    drive(v, d, c, r);
    @(posedge clk);
    modelUpdate(v, d, c, r);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic fillFrame(int gap_max, bit seq);
    for (int k = 0; k < N; k++) begin
      int gap = $urandom_range(gap_max, 0);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'($urandom), 1'b0, 1'($urandom));
      applyStimulus(1'b1, seq ? 8'(k) : 8'($urandom), 1'b0, 1'b1);
    end
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready
  task automatic drain(int mode, int exp_xfers);
    int xfers = 0;
    int cyc = 0;
    bit r;
    while (m_stream && cyc < 8 * N) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
      if (bus_nat.out_valid && r) xfers++;
      applyStimulus(1'b0, 8'($urandom), 1'b0, r);
      cyc++;
    end
    chk("drain_done", 32'(m_stream), 32'd0);
    if (exp_xfers > 0) chk("transfer_count", 32'(xfers), 32'(exp_xfers));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    rst = 1'b0;

    $display("[TB] frame with bit-reversed streaming, ready held high");
    fillFrame(1, 1'b1);
    drain(0, N);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] frame with ready toggling");
    fillFrame(2, 1'b0);
    drain(1, N);

    $display("[TB] strobes ignored while stalled in stream");
    fillFrame(0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0);
    end
    drain(0, N);

    $display("[TB] clear after a partial frame");
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b1);
    fillFrame(1, 1'b0);
    drain(2, N);

    $display("[TB] reset in the middle of a stream");
    fillFrame(0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
    fillFrame(1, 1'b1);
    drain(0, N);

    $display("[TB] strobe coincident with the final transfer");
    fillFrame(0, 1'b0);
    for (int cyc = 0; m_stream && cyc < 4 * N; cyc++) begin
      applyStimulus(m_sent == N - 1, 8'h5A, 1'b0, 1'b1);
    end
    chk("final_strobe_dropped", 32'(bus_nat.dropped), 32'd1);
    fillFrame(1, 1'b0);
    drain(2, N);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom), 8'($urandom), ($urandom_range(39, 0) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
